// File: rtl/caravel_gpio_wb.sv
`default_nettype none
// ============================================================================
// Module      : caravel_gpio_wb
// Description : Wishbone-controlled GPIO bank for the user project area.
//               Drives NUM_IO pads (io_out / io_oeb), samples io_in through a
//               two-flop synchroniser, detects per-pin rising / falling edges
//               into a sticky W1C status register and raises a masked,
//               registered level interrupt.
//
// Ports       : wb_clk_i / wb_rst_n_i      clock, async active-low reset
//               wbs_cyc_i .. wbs_dat_i     Wishbone classic slave inputs
//               wbs_dat_o / wbs_ack_o      Wishbone read data / acknowledge
//               io_in                      asynchronous pad inputs
//               io_out / io_oeb            pad output value / output-enable_n
//               irq                        level interrupt
//
// Register map (byte offsets within the 256-byte window):
//               0x00 DATA_IN  RO    0x04 DATA_OUT RW   0x08 OEB     RW
//               0x0C IRQ_MASK RW    0x10 RISE_EN  RW   0x14 FALL_EN RW
//               0x18 IRQ_STATUS W1C 0x1C DEBOUNCE RW (GPIO_DEBOUNCE_EN only)
//
// Build option: define GPIO_DEBOUNCE_EN to add the per-pin 3-sample input
//               filter and the DEBOUNCE prescaler register.
//
// Revision    : 1.0 - initial release
// ============================================================================
module caravel_gpio_wb #(
  parameter int          NUM_IO    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              irq
);

  localparam logic [5:0] c_off_data_in  = 6'h00;
  localparam logic [5:0] c_off_data_out = 6'h01;
  localparam logic [5:0] c_off_oeb      = 6'h02;
  localparam logic [5:0] c_off_mask     = 6'h03;
  localparam logic [5:0] c_off_rise_en  = 6'h04;
  localparam logic [5:0] c_off_fall_en  = 6'h05;
  localparam logic [5:0] c_off_status   = 6'h06;
`ifdef GPIO_DEBOUNCE_EN
  localparam logic [5:0] c_off_debounce = 6'h07;
`endif

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic              r_ack;
  logic [31:0]       r_dat;
  logic              w_hit;
  logic              w_acc;
  logic              w_wr;
  logic [5:0]        w_off;
  logic [31:0]       w_bmask;
  logic [NUM_IO-1:0] w_wmask;
  logic [NUM_IO-1:0] w_wdat;
  logic [31:0]       w_rdata;

  assign w_hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // An access is accepted only while ack is low, so a held strobe yields
  // one ack every other cycle rather than back-to-back acks.
  assign w_acc   = w_hit & ~r_ack;
  assign w_wr    = w_acc & wbs_we_i;
  assign w_off   = wbs_adr_i[7:2];
  assign w_bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                    {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign w_wmask = w_bmask[NUM_IO-1:0];
  assign w_wdat  = wbs_dat_i[NUM_IO-1:0];

  function automatic logic [NUM_IO-1:0] f_merge(
    input logic [NUM_IO-1:0] old_val,
    input logic [NUM_IO-1:0] new_val,
    input logic [NUM_IO-1:0] mask
  );
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  logic [NUM_IO-1:0] r_data_out;
  logic [NUM_IO-1:0] r_oeb;
  logic [NUM_IO-1:0] r_mask;
  logic [NUM_IO-1:0] r_rise_en;
  logic [NUM_IO-1:0] r_fall_en;
  logic [NUM_IO-1:0] r_status;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_data_out <= '0;
      r_oeb      <= '1;
      r_mask     <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
    end else if (w_wr) begin
      case (w_off)
        c_off_data_out: r_data_out <= f_merge(r_data_out, w_wdat, w_wmask);
        c_off_oeb:      r_oeb      <= f_merge(r_oeb,      w_wdat, w_wmask);
        c_off_mask:     r_mask     <= f_merge(r_mask,     w_wdat, w_wmask);
        c_off_rise_en:  r_rise_en  <= f_merge(r_rise_en,  w_wdat, w_wmask);
        c_off_fall_en:  r_fall_en  <= f_merge(r_fall_en,  w_wdat, w_wmask);
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Input path: synchroniser, optional filter, edge detect
  // --------------------------------------------------------------------------
  logic [NUM_IO-1:0] r_s1;
  logic [NUM_IO-1:0] r_s2;
  logic [NUM_IO-1:0] r_s3;
  logic [NUM_IO-1:0] w_filt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= io_in;
      r_s2 <= r_s1;
      r_s3 <= w_filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [15:0]       r_deb;
  logic [15:0]       r_pre;
  logic              w_tick;
  logic [NUM_IO-1:0] r_samp0;
  logic [NUM_IO-1:0] r_samp1;
  logic [NUM_IO-1:0] r_samp2;
  logic [NUM_IO-1:0] r_filt;
  logic              w_deb_wr;

  assign w_deb_wr = w_wr & (w_off == c_off_debounce);
  assign w_tick   = (r_pre == r_deb);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_deb <= '0;
      r_pre <= '0;
    end else begin
      if (w_deb_wr) begin
        r_deb <= (r_deb & ~w_bmask[15:0]) | (wbs_dat_i[15:0] & w_bmask[15:0]);
      end
      // A new DEBOUNCE value restarts the sampling period from zero.
      if (w_deb_wr || w_tick) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + 16'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_samp0 <= '0;
      r_samp1 <= '0;
      r_samp2 <= '0;
      r_filt  <= '0;
    end else begin
      if (w_tick) begin
        r_samp0 <= r_s2;
        r_samp1 <= r_samp0;
        r_samp2 <= r_samp1;
      end
      // Go high when all three samples are 1, low when all are 0, else hold.
      r_filt <= (r_samp0 & r_samp1 & r_samp2) |
                (r_filt & (r_samp0 | r_samp1 | r_samp2));
    end
  end

  // DEBOUNCE = 0 bypasses the filter so latency matches the unfiltered build.
  assign w_filt = (r_deb == 16'd0) ? r_s2 : r_filt;
`else
  assign w_filt = r_s2;
`endif

  logic [NUM_IO-1:0] w_set;
  logic [NUM_IO-1:0] w_clr;

  assign w_set = (w_filt & ~r_s3 & r_rise_en) | (~w_filt & r_s3 & r_fall_en);
  assign w_clr = (w_wr && (w_off == c_off_status)) ? (w_wdat & w_wmask) : '0;

  // A set arriving on the same edge as a W1C of that bit takes priority.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_clr) | w_set;
    end
  end

  logic r_irq;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_status & r_mask);
    end
  end

  // --------------------------------------------------------------------------
  // Read mux and acknowledge
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    case (w_off)
      c_off_data_in:  w_rdata[NUM_IO-1:0] = w_filt;
      c_off_data_out: w_rdata[NUM_IO-1:0] = r_data_out;
      c_off_oeb:      w_rdata[NUM_IO-1:0] = r_oeb;
      c_off_mask:     w_rdata[NUM_IO-1:0] = r_mask;
      c_off_rise_en:  w_rdata[NUM_IO-1:0] = r_rise_en;
      c_off_fall_en:  w_rdata[NUM_IO-1:0] = r_fall_en;
      c_off_status:   w_rdata[NUM_IO-1:0] = r_status;
`ifdef GPIO_DEBOUNCE_EN
      c_off_debounce: w_rdata[15:0]       = r_deb;
`endif
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !wbs_we_i) ? w_rdata : 32'd0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign io_out    = r_data_out;
  assign io_oeb    = r_oeb;
  assign irq       = r_irq;

  // Address LSBs and bits above the pad count are don't-care by design.
  logic w_unused;
  assign w_unused = &{1'b0, wbs_adr_i[1:0], wbs_dat_i, w_bmask};

endmodule
`default_nettype wire

// File: tb/tb_caravel_gpio_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_caravel_gpio_wb
// Description : Scoreboard bench for caravel_gpio_wb (NUM_IO = 10). Bus
//               accesses push their expected read data into a queue; a
//               monitor on the falling clock edge pops and compares on every
//               ack and also checks ack pulse width. Pad / irq timing is
//               checked directly from the stimulus thread.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_caravel_gpio_wb;

  localparam int          NUM_IO = 10;
  localparam logic [31:0] B      = 32'h3000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]        sel = 4'h0;
  logic [31:0]       adr = '0, wdat = '0;
  logic [31:0]       rdat;
  logic              ack;
  logic [NUM_IO-1:0] io_in = '0;
  logic [NUM_IO-1:0] io_out, io_oeb;
  logic              irq;

  caravel_gpio_wb #(.NUM_IO(NUM_IO), .BASE_ADDR(B)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(rdat), .wbs_ack_o(ack),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_ack = 1'b0;
  logic irq_at_ack = 1'b0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ack) begin
      irq_at_ack = irq;
      n_tests++;
      if (prev_ack) begin
        n_fail++;
        $display("FAIL ack_width: ack high on two consecutive cycles");
      end
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack with no access outstanding, dat 0x%08h", rdat);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.chk) begin
          n_tests++;
          if (rdat !== mon_e.data) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", mon_e.name, rdat, mon_e.data);
          end
        end
      end
    end
    prev_ack = ack;
  end

  task automatic bus(input logic [31:0] a_adr, input logic a_we, input logic [3:0] a_sel,
                     input logic [31:0] a_dat, input logic [31:0] a_exp, input string name);
    exp_t e;
    bit   got;
    e.data = a_exp;
    e.chk  = !a_we;
    e.name = name;
    q.push_back(e);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = a_we; sel = a_sel; adr = a_adr; wdat = a_dat;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s: no ack within 8 cycles, expected one", name);
      void'(q.pop_back());
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    bus(B + 32'(off), 1'b0, 4'hF, 32'd0, exp, name);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] s);
    bus(B + 32'(off), 1'b1, s, dat, 32'd0, "write");
  endtask

  // Access that must never be acknowledged.
  task automatic bus_miss(input logic [31:0] a_adr, input logic a_we, input string name);
    int acks;
    acks = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = a_we; sel = 4'hF; adr = a_adr; wdat = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check(name, 32'(acks), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",    32'(ack),    32'd0);
    check("rst_dat",    rdat,        32'd0);
    check("rst_io_out", 32'(io_out), 32'd0);
    check("rst_io_oeb", 32'(io_oeb), 32'h3FF);
    check("rst_irq",    32'(irq),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    rd(8'h00, 32'h0,   "rd_data_in");
    rd(8'h04, 32'h0,   "rd_data_out");
    rd(8'h08, 32'h3FF, "rd_oeb");
    rd(8'h0C, 32'h0,   "rd_mask");
    rd(8'h10, 32'h0,   "rd_rise_en");
    rd(8'h14, 32'h0,   "rd_fall_en");
    rd(8'h18, 32'h0,   "rd_status");
    rd(8'h1C, 32'h0,   "rd_debounce");

    // Byte enables
    wr(8'h04, 32'hFFFF_FFFF, 4'b0001);
    check("io_out_sel0", 32'(io_out), 32'h0FF);
    rd(8'h04, 32'h0000_00FF, "rd_data_out_sel0");
    wr(8'h04, 32'hFFFF_FFFF, 4'b0010);
    check("io_out_sel1", 32'(io_out), 32'h3FF);
    rd(8'h04, 32'h0000_03FF, "rd_data_out_sel1");
    wr(8'h08, 32'h0000_00F0, 4'hF);
    check("io_oeb_wr", 32'(io_oeb), 32'h0F0);
    rd(8'h08, 32'h0000_00F0, "rd_oeb_wr");

    // Rising edge on pin 0: status at edge 2, irq at edge 3
    wr(8'h10, 32'h1, 4'hF);
    wr(8'h0C, 32'h1, 4'hF);
    @(posedge clk); #1;
    io_in[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    check("irq_edge2_low", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("irq_edge3_high", 32'(irq), 32'd1);
    rd(8'h18, 32'h1, "rd_status_rise");
    rd(8'h00, 32'h1, "rd_data_in_pin0");

    // W1C: irq still high at the ack, low one cycle later
    wr(8'h18, 32'h1, 4'hF);
    check("irq_at_w1c_ack", 32'(irq_at_ack), 32'd1);
    check("irq_after_w1c", 32'(irq), 32'd0);
    rd(8'h18, 32'h0, "rd_status_cleared");

    // Set and W1C on the same edge: set wins
    io_in[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    io_in[0] = 1'b1;
    @(posedge clk);
    wr(8'h18, 32'h1, 4'hF);
    check("irq_set_wins", 32'(irq), 32'd1);
    rd(8'h18, 32'h1, "rd_status_set_wins");
    wr(8'h18, 32'h1, 4'hF);
    rd(8'h18, 32'h0, "rd_status_cleared2");

    // Falling edge on pin 1, masked then unmasked
    wr(8'h14, 32'h2, 4'hF);
    @(posedge clk); #1;
    io_in[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    io_in[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("irq_fall_masked", 32'(irq), 32'd0);
    rd(8'h18, 32'h2, "rd_status_fall");
    rd(8'h00, 32'h1, "rd_data_in_fall");
    wr(8'h0C, 32'h3, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("irq_fall_unmasked", 32'(irq), 32'd1);
    wr(8'h18, 32'h2, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("irq_fall_cleared", 32'(irq), 32'd0);

    // Outside the window, and unmapped in-window offset
    bus_miss(B + 32'h100, 1'b0, "miss_read_no_ack");
    bus_miss(B + 32'h104, 1'b1, "miss_write_no_ack");
    check("io_out_after_miss", 32'(io_out), 32'h3FF);
    rd(8'h20, 32'h0, "rd_unmapped");
    wr(8'h20, 32'hFFFF_FFFF, 4'hF);
    rd(8'h04, 32'h3FF, "rd_data_out_after_unmapped");

    // Held strobe: one ack every other cycle
    for (int i = 0; i < 3; i++) q.push_back('{32'h0000_00F0, 1'b1, "rd_held_stb"});
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = B + 32'h08;
    repeat (6) @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("held_stb_acks_consumed", 32'(q.size()), 32'd0);

`ifdef GPIO_DEBOUNCE_EN
    wr(8'h1C, 32'h0000_0003, 4'b0011);
    rd(8'h1C, 32'h3, "rd_debounce_3");
    wr(8'h10, 32'h3, 4'hF);
    @(posedge clk); #1;
    io_in[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    io_in[1] = 1'b0;
    repeat (20) @(posedge clk);
    rd(8'h18, 32'h0, "rd_status_glitch");
    #1;
    io_in[1] = 1'b1;
    repeat (25) @(posedge clk);
    rd(8'h18, 32'h2, "rd_status_level");
    rd(8'h00, 32'h3, "rd_data_in_level");
`endif

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
